// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared states and SD protocol constants for the SPI-mode card responder
package sd_spi_pkg;
  typedef enum logic [2:0] {RX_CMD, NCR, TX_RESP, READ_GAP, TX_TOKEN, TX_DATA, TX_CRC} state_t;
  localparam logic [5:0] CMD0 = 6'd0;
  localparam logic [5:0] CMD8 = 6'd8;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;
  localparam int R1_IDLE = 0;
  localparam int R1_ILLEGAL = 2;
  localparam int R1_CRC = 3;
  localparam logic [31:0] OCR_READY = 32'hC0FF8000;
  localparam logic [31:0] OCR_IDLE = 32'h40FF8000;
  localparam logic [7:0] DATA_TOKEN = 8'hFE;
  localparam int BLOCK_BYTES = 512;
endpackage

// File: rtl/sd_spi_crc7.sv
// sd_spi_crc7: bit-serial CRC7 (x^7+x^3+1); clr restarts the sum, and with en the current bit is the first one
module sd_spi_crc7 (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       d,
  output logic [6:0] crc
);
  logic [6:0] base;
  logic fb;
  always_comb begin
    base = clr ? 7'd0 : crc;
    fb = base[6] ^ d;
  end
  always_ff @(posedge clk)
    crc <= en ? ({base[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00)) : base;
endmodule

// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SPI-mode SD card model (CMD0/8/17/55/ACMD41/58); define SD_RESP_CRC_EN to check command CRC7
module sd_spi_responder
  import sd_spi_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int NAC_BYTES = 2
) (
  input  logic              iCLK_50,
  input  logic              reset,
  input  logic              SD_CLK,
  input  logic              SD_CS,
  input  logic              SD_MOSI,
  output logic              SD_MISO,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              card_idle
);
  localparam logic [8:0] LAST_BYTE = 9'(BLOCK_BYTES - 1);
  logic [1:0] clk_s, cs_s, mosi_s;
  logic clk_d, rise, fall, cs_hi, mosi, rx_en;
  state_t state;
  logic [46:0] cmd_sr;
  logic [47:0] frame;
  logic [5:0] bit_cnt;
  logic [7:0] tx_sr;
  logic [2:0] tx_bit;
  logic [39:0] resp;
  logic [2:0] resp_left;
  logic rd_pend;
  logic [ADDR_W-10:0] rd_blk;
  logic [3:0] cnt;
  logic [8:0] byte_idx;
  logic rd_q;
  logic [7:0] rdata_q;
  logic app;
  logic [5:0] idx;
  logic [31:0] arg;
  logic acmd41, ill, idle_c, app_c, rd_c, crc_bad;
  logic [7:0] r1;
  logic [39:0] resp_c;
  logic [2:0] len_c;
  logic unused_bits;

  always_ff @(posedge iCLK_50) begin
    clk_s <= {clk_s[0], SD_CLK};
    cs_s <= {cs_s[0], SD_CS};
    mosi_s <= {mosi_s[0], SD_MOSI};
    clk_d <= clk_s[1];
    rd_q <= mem_rd;
    if (rd_q) rdata_q <= mem_rdata;
  end

  assign rise = clk_s[1] & ~clk_d;
  assign fall = ~clk_s[1] & clk_d;
  assign cs_hi = cs_s[1];
  assign mosi = mosi_s[1];
  assign frame = {cmd_sr, mosi};
  assign rx_en = ~reset & ~cs_hi & (state == RX_CMD) & rise & ((bit_cnt != 6'd0) | ~mosi);
  assign unused_bits = ^{frame[47], frame[39:0]};

`ifdef SD_RESP_CRC_EN
  logic [6:0] crc;
  sd_spi_crc7 u_crc (
    .clk(iCLK_50),
    .clr(reset | (bit_cnt == 6'd0)),
    .en (rx_en & (bit_cnt < 6'd40)),
    .d  (mosi),
    .crc(crc)
  );
  assign crc_bad = crc != frame[7:1];
`else
  assign crc_bad = 1'b0;
`endif

  // Decode of the frame completing on this sample, including its effect on idle/app state
  always_comb begin
    idx = frame[45:40];
    arg = frame[39:8];
    acmd41 = (idx == CMD41) & app;
    ill = !(idx inside {CMD0, CMD8, CMD17, CMD55, CMD58}) & ~acmd41;
    idle_c = crc_bad ? card_idle : (idx == CMD0) ? 1'b1 : acmd41 ? 1'b0 : card_idle;
    app_c = ~crc_bad & (idx == CMD55);
    rd_c = ~crc_bad & (idx == CMD17) & ~card_idle;
    r1 = crc_bad ? ((8'd1 << R1_CRC) | (8'(card_idle) << R1_IDLE)) :
         ((idx == CMD17) & card_idle) ? 8'h05 :
         ((8'(ill) << R1_ILLEGAL) | (8'(idle_c) << R1_IDLE));
    resp_c = crc_bad ? {r1, 32'hFFFFFFFF} :
             (idx == CMD8) ? {r1, 8'h00, 8'h00, 4'h0, arg[11:8], arg[7:0]} :
             (idx == CMD58) ? {r1, card_idle ? OCR_IDLE : OCR_READY} : {r1, 32'hFFFFFFFF};
    len_c = (~crc_bad & ((idx == CMD8) | (idx == CMD58))) ? 3'd4 : 3'd0;
  end

  always_ff @(posedge iCLK_50) begin
    mem_rd <= 1'b0;
    if (reset) begin
      state <= RX_CMD;
      SD_MISO <= 1'b1;
      mem_addr <= '0;
      card_idle <= 1'b1;
      app <= 1'b0;
      bit_cnt <= '0;
      tx_bit <= '0;
      byte_idx <= '0;
      cnt <= '0;
    end else if (cs_hi) begin
      state <= RX_CMD;
      SD_MISO <= 1'b1;
      bit_cnt <= '0;
      tx_bit <= '0;
      byte_idx <= '0;
      cnt <= '0;
    end else if (state == RX_CMD) begin
      if (fall) SD_MISO <= 1'b1;
      if (rx_en) begin
        cmd_sr <= frame[46:0];
        bit_cnt <= (bit_cnt == 6'd47) ? 6'd0 : bit_cnt + 6'd1;
        if ((bit_cnt == 6'd47) && frame[46]) begin
          state <= NCR;
          tx_sr <= 8'hFF;
          tx_bit <= '0;
          resp <= resp_c;
          resp_left <= len_c;
          rd_pend <= rd_c;
          rd_blk <= frame[ADDR_W-2:8];
          card_idle <= idle_c;
          app <= app_c;
        end
      end
    end else if (fall) begin
      SD_MISO <= tx_sr[7];
      tx_sr <= {tx_sr[6:0], 1'b1};
      tx_bit <= tx_bit + 3'd1;
      // Fetch the next data byte a full byte time ahead of its load
      if ((tx_bit == 3'd0) && ((state == TX_TOKEN) || ((state == TX_DATA) && (byte_idx != LAST_BYTE)))) begin
        mem_rd <= 1'b1;
        mem_addr <= {rd_blk, (state == TX_TOKEN) ? 9'd0 : byte_idx + 9'd1};
      end
      if (tx_bit == 3'd7) begin
        case (state)
          NCR: begin
            tx_sr <= resp[39:32];
            resp <= {resp[31:0], 8'hFF};
            state <= TX_RESP;
          end
          TX_RESP: begin
            if (resp_left != 3'd0) begin
              tx_sr <= resp[39:32];
              resp <= {resp[31:0], 8'hFF};
              resp_left <= resp_left - 3'd1;
            end else if (rd_pend) begin
              tx_sr <= 8'hFF;
              cnt <= 4'(NAC_BYTES - 1);
              state <= READ_GAP;
            end else state <= RX_CMD;
          end
          READ_GAP: begin
            tx_sr <= (cnt == 4'd0) ? DATA_TOKEN : 8'hFF;
            state <= (cnt == 4'd0) ? TX_TOKEN : READ_GAP;
            cnt <= cnt - 4'd1;
          end
          TX_TOKEN: begin
            tx_sr <= rdata_q;
            byte_idx <= '0;
            state <= TX_DATA;
          end
          TX_DATA: begin
            if (byte_idx == LAST_BYTE) begin
              tx_sr <= 8'hFF;
              cnt <= 4'd1;
              state <= TX_CRC;
            end else begin
              tx_sr <= rdata_q;
              byte_idx <= byte_idx + 9'd1;
            end
          end
          TX_CRC: begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd0) state <= RX_CMD;
          end
          default: state <= RX_CMD;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sd_spi_responder.sv
// tb_sd_spi_responder: table-driven command checks plus read, CS-abort, CRC and reset sequences
module tb_sd_spi_responder;
  localparam int ADDR_W = 16;
  localparam int NAC = 2;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    int          n;
    logic [47:0] exp;
    logic        idle;
  } vec_t;

  logic iCLK_50 = 1'b0;
  logic reset = 1'b1;
  logic SD_CLK = 1'b0;
  logic SD_CS = 1'b1;
  logic SD_MOSI = 1'b1;
  logic SD_MISO, mem_rd, card_idle;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0] mem_rdata;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [ADDR_W-1:0] addr_log[$];
  vec_t vecs[9];

  sd_spi_responder #(.ADDR_W(ADDR_W), .NAC_BYTES(NAC)) dut (
    .iCLK_50(iCLK_50), .reset(reset), .SD_CLK(SD_CLK), .SD_CS(SD_CS), .SD_MOSI(SD_MOSI),
    .SD_MISO(SD_MISO), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .card_idle(card_idle)
  );

  always #10 iCLK_50 = ~iCLK_50;

  always @(posedge iCLK_50)
    if (mem_rd) begin
      mem_rdata <= mem_addr[7:0];
      addr_log.push_back(mem_addr);
    end

  function automatic logic [7:0] crc_byte(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] bits;
    logic [6:0] c;
    logic fb;
    bits = {2'b01, idx, arg};
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ bits[i];
      c = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return {c, 1'b1};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      SD_MOSI = tx[i];
      repeat (5) @(negedge iCLK_50);
      rx[i] = SD_MISO;
      SD_CLK = 1'b1;
      repeat (5) @(negedge iCLK_50);
      SD_CLK = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [47:0] f);
    logic [7:0] rx;
    for (int b = 0; b < 6; b++) xfer(f[47-8*b -: 8], rx);
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg);
    send_frame({2'b01, idx, arg, crc_byte(idx, arg)});
  endtask

  task automatic drain(input string name);
    logic [7:0] rx, e;
    while (exp_q.size() > 0) begin
      xfer(8'hFF, rx);
      e = exp_q.pop_front();
      check(name, {24'd0, rx}, {24'd0, e});
    end
  endtask

  task automatic push_read_head();
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    for (int i = 0; i < NAC; i++) exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFE);
  endtask

  initial begin
    int base;
    vecs[0] = '{6'd0,  32'h0,        2, {8'hFF, 8'h01, 32'h0}, 1'b1};
    vecs[1] = '{6'd17, 32'h5,        2, {8'hFF, 8'h05, 32'h0}, 1'b1};
    vecs[2] = '{6'd8,  32'h1AA,      6, {8'hFF, 8'h01, 8'h00, 8'h00, 8'h01, 8'hAA}, 1'b1};
    vecs[3] = '{6'd41, 32'h40000000, 2, {8'hFF, 8'h05, 32'h0}, 1'b1};
    vecs[4] = '{6'd55, 32'h0,        2, {8'hFF, 8'h01, 32'h0}, 1'b1};
    vecs[5] = '{6'd41, 32'h40000000, 2, {8'hFF, 8'h00, 32'h0}, 1'b0};
    vecs[6] = '{6'd58, 32'h0,        6, {8'hFF, 8'h00, 8'hC0, 8'hFF, 8'h80, 8'h00}, 1'b0};
    vecs[7] = '{6'd13, 32'h0,        2, {8'hFF, 8'h04, 32'h0}, 1'b0};
    vecs[8] = '{6'd8,  32'h2A5,      6, {8'hFF, 8'h00, 8'h00, 8'h00, 8'h02, 8'hA5}, 1'b0};

    repeat (5) @(negedge iCLK_50);
    check("reset_miso", {31'd0, SD_MISO}, 32'd1);
    check("reset_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("reset_idle", {31'd0, card_idle}, 32'd1);
    reset = 1'b0;
    repeat (3) @(negedge iCLK_50);
    SD_CS = 1'b0;
    repeat (10) @(negedge iCLK_50);

    for (int i = 0; i < 9; i++) begin
      send_cmd(vecs[i].idx, vecs[i].arg);
      for (int k = 0; k < vecs[i].n; k++) exp_q.push_back(vecs[i].exp[47-8*k -: 8]);
      drain($sformatf("vec%0d_cmd%0d", i, vecs[i].idx));
      check($sformatf("vec%0d_idle", i), {31'd0, card_idle}, {31'd0, vecs[i].idle});
    end

    send_cmd(6'd17, 32'h5);
    push_read_head();
    for (int i = 0; i < 512; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    base = addr_log.size();
    drain("cmd17_block");
    check("cmd17_rd_count", addr_log.size() - base, 32'd512);
    check("cmd17_first_addr", {16'd0, addr_log[base]}, 32'h0A00);
    check("cmd17_last_addr", {16'd0, addr_log[base+511]}, 32'h0BFF);

    send_cmd(6'd17, 32'h5);
    push_read_head();
    for (int i = 0; i <= 100; i++) exp_q.push_back(8'(i));
    drain("cs_abort_data");
    SD_CS = 1'b1;
    base = addr_log.size();
    repeat (3) @(negedge iCLK_50);
    check("cs_abort_miso", {31'd0, SD_MISO}, 32'd1);
    repeat (100) @(negedge iCLK_50);
    check("cs_abort_rd_silent", addr_log.size() - base, 32'd0);
    SD_CS = 1'b0;
    repeat (10) @(negedge iCLK_50);
    send_cmd(6'd0, 32'h0);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h01);
    drain("cmd0_after_abort");
    check("cmd0_after_abort_idle", {31'd0, card_idle}, 32'd1);

    send_frame(48'h00_00_00_00_00_01);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    drain("tx0_discard");

    send_frame(48'h40_00_00_00_00_97);
    exp_q.push_back(8'hFF);
`ifdef SD_RESP_CRC_EN
    exp_q.push_back(8'h09);
`else
    exp_q.push_back(8'h01);
`endif
    drain("cmd0_bad_crc");
    check("cmd0_bad_crc_idle", {31'd0, card_idle}, 32'd1);

    send_cmd(6'd8, 32'h1AA);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h01);
    drain("cmd8_pre_reset");
    repeat (4) @(negedge iCLK_50);
    check("pre_reset_miso_low", {31'd0, SD_MISO}, 32'd0);
    reset = 1'b1;
    @(negedge iCLK_50);
    check("midreset_miso", {31'd0, SD_MISO}, 32'd1);
    check("midreset_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("midreset_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("midreset_idle", {31'd0, card_idle}, 32'd1);
    reset = 1'b0;
    repeat (5) @(negedge iCLK_50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
